mem_access_stage: RTL

MEM stage of the five-stage MIPS pipeline: sits between the EX/MEM register and the MEM/WB register. Performs loads and stores through a request/acknowledge data-memory port, with byte/half/word sizing and alignment checking. Stalls the pipeline while an access is outstanding, and presents aligned, extended load data plus pass-through control to the MEM/WB register.

---
 rtl/mem_access_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: sized, alignment-checked loads and stores over a req/ack data-memory port.
// Stalls upstream from op detection until ack or timeout; DONE presents extended load data.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] ALU_result,
    input  logic [31:0] store_data,
    input  logic        reg_write,
    input  logic [4:0]  reg_address,
    input  logic        jump_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error,
    output logic        reg_write_out,
    output logic [31:0] data_out,
    output logic [31:0] result_out,
    output logic [4:0]  reg_address_out,
    output logic        jump_reg_out
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] load_buf_q;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        abort_q;
    logic        req_q;
    logic        we_q;
    logic        mis_q;
    logic        berr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        mem_op;
    logic        is_half;
    logic        is_word;
    logic        fault;
    logic        start;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] ext;

    assign mem_op  = mem_read | mem_write;
    assign is_half = (mem_size == 2'b01);
    assign is_word = mem_size[1];
    assign fault   = (state_q == IDLE) & mem_op &
                     ((is_half & ALU_result[0]) | (is_word & (|ALU_result[1:0])));
    assign start   = (state_q == IDLE) & mem_op & ~fault;

    // Lane-replicated store data so memory needs only the byte enables.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data;
        case (mem_size)
            2'b00: begin
                be_d    = 4'b0001 << ALU_result[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_d    = ALU_result[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane = load_buf_q >> {lo_q, 3'b000};
        ext  = lane;
        case (size_q)
            2'b00: ext = uns_q ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            2'b01: ext = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            load_buf_q <= 32'd0;
            lo_q       <= 2'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            abort_q    <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
        end else begin
            mis_q  <= fault;
            berr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        req_q   <= 1'b1;
                        we_q    <= mem_write;
                        addr_q  <= {ALU_result[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        lo_q    <= ALU_result[1:0];
                        size_q  <= mem_size;
                        uns_q   <= mem_unsigned;
                        cnt_q   <= 8'd0;
                        abort_q <= 1'b0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        load_buf_q <= dmem_rdata;
                        req_q      <= 1'b0;
                        state_q    <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        berr_q  <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                // EX/MEM advances on this edge, so the held inputs are not looked at again.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall           = start | (state_q == ACCESS);
    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_be         = be_q;
    assign dmem_wdata      = wdata_q;
    assign misaligned      = mis_q;
    assign bus_error       = berr_q;
    assign reg_write_out   = reg_write & ~stall & ~fault & ~((state_q == DONE) & abort_q);
    assign data_out        = (state_q == DONE) ? ext : 32'd0;
    assign result_out      = ALU_result;
    assign reg_address_out = reg_address;
    assign jump_reg_out    = jump_reg;
endmodule
